data_ram_be: RTL
================

Name: data_ram_be

Overview:
Parametrised data memory for the pipeline CPU. It replaces the word-only data RAM with byte-addressed access, byte/half/word sizes, sign- or zero-extended loads, write-first forwarding between the WB write port and the MEM read port, and misalignment detection. It has one write port and one read port on a single clock. The read is registered with 1-cycle latency, and dout is driven from a register.

Parameters:
DATA_WIDTH, 32, memory word width in bits; power of two, at least 32.
ADDR_WIDTH, 12, byte-address width.
OFF (localparam), log2(DATA_WIDTH/8), number of byte-offset bits.
DEPTH (localparam), 1 << (ADDR_WIDTH-OFF), number of words.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
w_en  in  1  write request (WB stage).
w_addr  in  ADDR_WIDTH  byte address of the write.
w_size  in  2  write size: 00 byte, 01 half, 10 word (32b), 11 full DATA_WIDTH.
din  in  DATA_WIDTH  store data, right-aligned (LSBs).
r_en  in  1  read request (MEM stage).
r_addr  in  ADDR_WIDTH  byte address of the read.
r_size  in  2  read size, same encoding as w_size.
r_signed  in  1  1 = sign-extend the loaded value, 0 = zero-extend; ignored when r_size=11.
dout  out  DATA_WIDTH  load result, registered.
r_valid  out  1  dout holds the result of an accepted read.
misalign_err  out  1  one-cycle pulse after a misaligned access.

Behaviour:
- Reset (rst_n low, asynchronous): dout=0, r_valid=0, misalign_err=0.
  - Array writes are suppressed while rst_n is low.
  - Array contents are not reset; benches initialise them by writing.
- Word index = addr[ADDR_WIDTH-1:OFF]. Lane offset = addr[OFF-1:0].
- Alignment rules:
  - Half requires addr[0]=0.
  - Word requires addr[1:0]=0.
  - Full requires addr[OFF-1:0]=0.
  - Byte accesses are always aligned.
  - When DATA_WIDTH=32, size 10 and size 11 are identical.
- Write, at the edge where w_en=1 and the access is aligned:
  - Only the addressed byte lanes are updated: 1, 2, 4 or DATA_WIDTH/8 bytes starting at the lane offset.
  - The lanes are written from din[7:0], din[15:0], din[31:0] or all of din.
  - All other bytes of the word are unchanged.
  - A misaligned write is dropped entirely and the array is unchanged.
- Read, at the edge where r_en=1 and the access is aligned:
  - The target word is captured. If a write to the same word index is accepted at that same edge, the captured word is the merged post-write value (write-first forwarding).
  - The addressed lanes are shifted down to the LSBs, then sign- or zero-extended to DATA_WIDTH.
  - The result is registered into dout and r_valid is set to 1.
- Latency is exactly 1 cycle: a request sampled at edge E is visible on dout/r_valid after E and holds until edge E+1.
  - A write accepted at edge E+1 never alters the dout value that was captured at edge E.
- At an edge with no accepted read (r_en=0, or the read is misaligned): dout <= 0 and r_valid <= 0.
- misalign_err is registered: it is 1 for exactly one cycle after any edge where r_en or w_en carried a misaligned access (either port), otherwise 0.
- Independent ports: a write and a read to different words in the same cycle do not interact.
- Back-to-back accesses: reads are accepted every cycle and writes are accepted every cycle; no stalls, no backpressure.
- Address wrap: none. Every ADDR_WIDTH address maps to a distinct byte.

Test Plan:
- Word write/read: write 0xDEADBEEF at 0x010 (size 10) → read word at 0x010 gives dout=0xDEADBEEF, r_valid=1 exactly one cycle after the read request; with r_en=0 the next cycle, dout=0 and r_valid=0.
- Byte lanes and extension: word 0x11223344 at 0x020; write byte 0x80 at 0x021 → word becomes 0x11228044.
  - Signed byte load at 0x021 → 0xFFFFFF80; unsigned → 0x00000080.
  - Signed half load at 0x022 → 0x00001122.
- Forwarding: in the same cycle, write half 0xABCD at 0x032 and read word at 0x030 (old contents 0x00000000) → dout=0xABCD0000.
  - In the next cycle, write 0x0 to 0x030 → the held dout stays 0xABCD0000 until the following edge.
- Misalignment: write word at 0x041 → misalign_err=1 for one cycle and 0x040 is unchanged.
  - Read half at 0x043 → misalign_err=1, r_valid=0, dout=0.
- Reset mid-operation: assert rst_n low between edges while r_valid=1 → dout=0 and r_valid=0 immediately.
  - A w_en held high during reset has no effect on the array.
  - After release, the first read returns pre-reset memory contents.
- DATA_WIDTH=64: full-width write 0x0123456789ABCDEF at 0x008, then signed word read at 0x00C → 0x0000000001234567.
  - Word read at 0x004 → misalign_err=0, since 0x004 is 4-byte aligned.

Source files
------------

// File: rtl/data_ram_be.sv
// rtl/data_ram_be.sv - byte-addressed data RAM with sized, sign/zero-extended, write-first loads
//
// One write port (WB stage) and one registered read port (MEM stage) on a single clock.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   w_en/w_addr/w_size  write request: byte address, size (00 byte, 01 half, 10 word, 11 full)
//   din                 store data, right-aligned
//   r_en/r_addr/r_size  read request: byte address, size (same encoding)
//   r_signed            sign-extend (1) or zero-extend (0) the loaded lanes
//   dout                registered load result (0 when no read was accepted)
//   r_valid             dout holds the result of an accepted read
//   misalign_err        one-cycle pulse after a misaligned access on either port
module data_ram_be #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  w_en,
   input  logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [1:0]            w_size,
   input  logic [DATA_WIDTH-1:0] din,
   input  logic                  r_en,
   input  logic [ADDR_WIDTH-1:0] r_addr,
   input  logic [1:0]            r_size,
   input  logic                  r_signed,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  r_valid,
   output logic                  misalign_err
);

   localparam int OFF   = $clog2(DATA_WIDTH / 8);
   localparam int IW    = ADDR_WIDTH - OFF;
   localparam int DEPTH = 1 << IW;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];

   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic                  r_valid_q, r_valid_d;
   logic                  misalign_q, misalign_d;

   logic [IW-1:0]         w_idx, r_idx;
   logic [OFF-1:0]        w_off, r_off;
   logic                  w_align, r_align, w_ok, r_ok;
   logic [DATA_WIDTH-1:0] w_lane_mask, w_shift, w_merged;
   logic [DATA_WIDTH-1:0] r_word, r_shift, r_mask;
   logic                  r_sign, r_ext;

   function automatic logic is_aligned(input logic [OFF-1:0] off, input logic [1:0] size);
      logic ok;
      case (size)
         2'b00:   ok = 1'b1;
         2'b01:   ok = (off[0] == 1'b0);
         2'b10:   ok = (off[1:0] == 2'b00);
         default: ok = (off == '0);
      endcase
      return ok;
   endfunction

   // Right-aligned mask covering the bytes moved by an access of the given size.
   function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [1:0] size);
      logic [DATA_WIDTH-1:0] ones;
      logic [DATA_WIDTH-1:0] m;
      ones = '1;
      case (size)
         2'b00:   m = ones >> (DATA_WIDTH - 8);
         2'b01:   m = ones >> (DATA_WIDTH - 16);
         2'b10:   m = ones >> (DATA_WIDTH - 32);
         default: m = ones;
      endcase
      return m;
   endfunction

   always_comb begin
      w_idx       = w_addr[ADDR_WIDTH-1:OFF];
      w_off       = w_addr[OFF-1:0];
      w_align     = is_aligned(w_off, w_size);
      w_ok        = w_en && w_align;
      w_lane_mask = size_mask(w_size) << {w_off, 3'b000};
      w_shift     = din << {w_off, 3'b000};
      w_merged    = (mem_q[w_idx] & ~w_lane_mask) | (w_shift & w_lane_mask);

      r_idx   = r_addr[ADDR_WIDTH-1:OFF];
      r_off   = r_addr[OFF-1:0];
      r_align = is_aligned(r_off, r_size);
      r_ok    = r_en && r_align;

      // Write-first: a same-edge write to the read word is seen by the read.
      r_word  = (w_ok && (w_idx == r_idx)) ? w_merged : mem_q[r_idx];
      r_shift = r_word >> {r_off, 3'b000};
      r_mask  = size_mask(r_size);

      case (r_size)
         2'b00:   r_sign = r_shift[7];
         2'b01:   r_sign = r_shift[15];
         2'b10:   r_sign = r_shift[31];
         default: r_sign = 1'b0;
      endcase
      r_ext = r_signed && r_sign && (r_size != 2'b11);

      dout_d     = r_ok ? ((r_shift & r_mask) | (r_ext ? ~r_mask : '0)) : '0;
      r_valid_d  = r_ok;
      misalign_d = (w_en && !w_align) || (r_en && !r_align);
   end

   // Array has no reset; writes are only blocked while reset is held.
   always_ff @(posedge clk) begin
      if (rst_n && w_ok) begin
         mem_q[w_idx] <= w_merged;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q     <= '0;
         r_valid_q  <= 1'b0;
         misalign_q <= 1'b0;
      end else begin
         dout_q     <= dout_d;
         r_valid_q  <= r_valid_d;
         misalign_q <= misalign_d;
      end
   end

   assign dout         = dout_q;
   assign r_valid      = r_valid_q;
   assign misalign_err = misalign_q;

endmodule
